// File: rtl/edge_pe_task_buffer_if.sv
// Handshake bundle between the reservation station, the task buffer and the four Edge PEs.
// The buffer uses the slave modport; upstream/PE-side logic (or a bench) uses master.
interface edge_pe_task_buffer_if #(
  parameter int NUM_PE = 4,
  parameter int PKT_W  = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_PE-1:0][PKT_W-1:0] task_packet;
  logic [NUM_PE-1:0]            task_valid;
  logic                         flush;
  logic [NUM_PE-1:0]            pe_idle;
  logic [NUM_PE-1:0]            pe_done;
  logic [NUM_PE-1:0][PKT_W-1:0] pe_packet;
  logic [NUM_PE-1:0]            pe_valid;
  logic [NUM_PE-1:0]            lane_full;
  logic [NUM_PE-1:0][CW-1:0]    lane_count;
  logic                         all_drained;
  logic                         overflow_err;

  modport master (
    output task_packet, task_valid, flush, pe_idle, pe_done,
    input  pe_packet, pe_valid, lane_full, lane_count, all_drained, overflow_err
  );

  modport slave (
    input  task_packet, task_valid, flush, pe_idle, pe_done,
    output pe_packet, pe_valid, lane_full, lane_count, all_drained, overflow_err
  );
endinterface

// File: rtl/edge_pe_task_buffer.sv
// Per-lane task FIFOs feeding four Edge PEs; one task in flight per PE, issue only when the PE is idle.
// Latency: push at t, pop at t+1, pe_valid at t+2; a full lane drops pushes (sticky overflow_err) unless it pops that cycle.
module edge_pe_task_buffer #(
  parameter int NUM_PE = 4,
  parameter int PKT_W  = 16,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  reset,
  edge_pe_task_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PKT_W-1:0]             r_mem      [NUM_PE][DEPTH];
  logic [AW-1:0]                r_wr_ptr   [NUM_PE];
  logic [AW-1:0]                r_rd_ptr   [NUM_PE];
  logic [CW-1:0]                r_count    [NUM_PE];
  logic [NUM_PE-1:0]            r_inflight;
  logic [NUM_PE-1:0]            r_pe_valid;
  logic [NUM_PE-1:0]            r_lane_full;
  logic [NUM_PE-1:0][PKT_W-1:0] r_pe_packet;
  logic                         r_all_drained;
  logic                         r_overflow_err;

  logic [NUM_PE-1:0] w_pop;
  logic [NUM_PE-1:0] w_push;
  logic [NUM_PE-1:0] w_drop;
  logic [NUM_PE-1:0] w_inflight_nxt;
  logic [NUM_PE-1:0] w_full_nxt;
  logic [CW-1:0]     w_count_nxt [NUM_PE];
  logic              w_drained_nxt;

  // A full lane still accepts a push when its head leaves in the same cycle.
  always_comb begin
    w_drained_nxt = 1'b1;
    for (int i = 0; i < NUM_PE; i++) begin
      w_pop[i]  = (r_count[i] != '0) && bus.pe_idle[i] && !r_inflight[i] && !bus.flush;
      w_push[i] = bus.task_valid[i] && !bus.flush && ((r_count[i] != FULL_CNT) || w_pop[i]);
      w_drop[i] = bus.task_valid[i] && !bus.flush && !w_push[i];
      w_count_nxt[i] = bus.flush ? '0 : (r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]));
      w_full_nxt[i]  = (w_count_nxt[i] == FULL_CNT);
      w_inflight_nxt[i] = (r_inflight[i] && !bus.pe_done[i]) || w_pop[i];
      if ((w_count_nxt[i] != '0) || w_inflight_nxt[i]) begin
        w_drained_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_inflight     <= '0;
      r_pe_valid     <= '0;
      r_lane_full    <= '0;
      r_pe_packet    <= '0;
      r_all_drained  <= 1'b1;
      r_overflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (bus.flush) begin
          r_wr_ptr[i] <= '0;
          r_rd_ptr[i] <= '0;
        end else begin
          if (w_push[i]) begin
            r_mem[i][r_wr_ptr[i]] <= bus.task_packet[i];
            r_wr_ptr[i]           <= r_wr_ptr[i] + AW'(1);
          end
          if (w_pop[i]) begin
            r_pe_packet[i] <= r_mem[i][r_rd_ptr[i]];
            r_rd_ptr[i]    <= r_rd_ptr[i] + AW'(1);
          end
        end
        r_count[i] <= w_count_nxt[i];
      end
      r_inflight     <= w_inflight_nxt;
      r_pe_valid     <= w_pop;
      r_lane_full    <= w_full_nxt;
      r_all_drained  <= w_drained_nxt;
      r_overflow_err <= r_overflow_err | (|w_drop);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      bus.lane_count[i] = r_count[i];
    end
  end

  assign bus.pe_packet    = r_pe_packet;
  assign bus.pe_valid     = r_pe_valid;
  assign bus.lane_full    = r_lane_full;
  assign bus.all_drained  = r_all_drained;
  assign bus.overflow_err = r_overflow_err;
endmodule

// File: tb/tb_edge_pe_task_buffer.sv
// Directed bench for edge_pe_task_buffer: one task per scenario, hand-computed expectations.
module tb_edge_pe_task_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  edge_pe_task_buffer_if bus ();
  edge_pe_task_buffer dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.task_valid  = '0;
    bus.task_packet = '0;
    bus.flush       = 1'b0;
    bus.pe_idle     = '0;
    bus.pe_done     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL reset_pe_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    n_total++; if (bus.pe_packet !== '0) $display("FAIL reset_pe_packet got=%h exp=0", bus.pe_packet); else n_pass++;
    n_total++; if (bus.lane_full !== 4'h0) $display("FAIL reset_lane_full got=%h exp=0", bus.lane_full); else n_pass++;
    n_total++; if (bus.lane_count !== '0) $display("FAIL reset_lane_count got=%h exp=0", bus.lane_count); else n_pass++;
    n_total++; if (bus.all_drained !== 1'b1) $display("FAIL reset_all_drained got=%b exp=1", bus.all_drained); else n_pass++;
    n_total++; if (bus.overflow_err !== 1'b0) $display("FAIL reset_overflow_err got=%b exp=0", bus.overflow_err); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    bus.pe_idle = 4'hF;
    bus.task_valid = 4'b0001;
    bus.task_packet[0] = 16'hA5A5;
    tick();
    bus.task_valid = '0;
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL single_t1_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    n_total++; if (bus.lane_count[0] !== 3'd1) $display("FAIL single_t1_count got=%0d exp=1", bus.lane_count[0]); else n_pass++;
    n_total++; if (bus.all_drained !== 1'b0) $display("FAIL single_t1_drained got=%b exp=0", bus.all_drained); else n_pass++;
    tick();
    n_total++; if (bus.pe_valid !== 4'b0001) $display("FAIL single_t2_valid got=%h exp=1", bus.pe_valid); else n_pass++;
    n_total++; if (bus.pe_packet[0] !== 16'hA5A5) $display("FAIL single_t2_packet got=%h exp=a5a5", bus.pe_packet[0]); else n_pass++;
    n_total++; if (bus.lane_count[0] !== 3'd0) $display("FAIL single_t2_count got=%0d exp=0", bus.lane_count[0]); else n_pass++;
    tick();
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL single_t3_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    n_total++; if (bus.pe_packet[0] !== 16'hA5A5) $display("FAIL single_hold_packet got=%h exp=a5a5", bus.pe_packet[0]); else n_pass++;
    n_total++; if (bus.all_drained !== 1'b0) $display("FAIL single_inflight_drained got=%b exp=0", bus.all_drained); else n_pass++;
    bus.pe_done = 4'b0001;
    tick();
    bus.pe_done = '0;
    n_total++; if (bus.all_drained !== 1'b1) $display("FAIL single_done_drained got=%b exp=1", bus.all_drained); else n_pass++;
  endtask

  task automatic test_serialise();
    do_reset();
    bus.task_valid = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      bus.task_packet[2] = 16'(k);
      tick();
    end
    bus.task_valid = '0;
    n_total++; if (bus.lane_count[2] !== 3'd3) $display("FAIL ser_count3 got=%0d exp=3", bus.lane_count[2]); else n_pass++;
    bus.pe_idle = 4'hF;
    tick();
    n_total++; if (bus.pe_valid !== 4'b0100) $display("FAIL ser_first_valid got=%h exp=4", bus.pe_valid); else n_pass++;
    n_total++; if (bus.pe_packet[2] !== 16'h0001) $display("FAIL ser_first_packet got=%h exp=0001", bus.pe_packet[2]); else n_pass++;
    n_total++; if (bus.lane_count[2] !== 3'd2) $display("FAIL ser_count2 got=%0d exp=2", bus.lane_count[2]); else n_pass++;
    tick();
    tick();
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL ser_busy_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    n_total++; if (bus.lane_count[2] !== 3'd2) $display("FAIL ser_busy_count got=%0d exp=2", bus.lane_count[2]); else n_pass++;
    bus.pe_done = 4'b0100;
    tick();
    bus.pe_done = '0;
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL ser_done_edge_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    tick();
    n_total++; if (bus.pe_valid !== 4'b0100) $display("FAIL ser_second_valid got=%h exp=4", bus.pe_valid); else n_pass++;
    n_total++; if (bus.pe_packet[2] !== 16'h0002) $display("FAIL ser_second_packet got=%h exp=0002", bus.pe_packet[2]); else n_pass++;
    n_total++; if (bus.lane_count[2] !== 3'd1) $display("FAIL ser_count1 got=%0d exp=1", bus.lane_count[2]); else n_pass++;
    bus.pe_done = 4'b0100;
    tick();
    bus.pe_done = '0;
    tick();
    n_total++; if (bus.pe_packet[2] !== 16'h0003) $display("FAIL ser_third_packet got=%h exp=0003", bus.pe_packet[2]); else n_pass++;
    n_total++; if (bus.lane_count[2] !== 3'd0) $display("FAIL ser_count0 got=%0d exp=0", bus.lane_count[2]); else n_pass++;
    bus.pe_done = 4'b0100;
    tick();
    bus.pe_done = '0;
    n_total++; if (bus.all_drained !== 1'b1) $display("FAIL ser_drained got=%b exp=1", bus.all_drained); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.task_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      bus.task_packet[1] = 16'h0010 + 16'(k);
      tick();
    end
    n_total++; if (bus.lane_full !== 4'b0010) $display("FAIL ovf_full got=%h exp=2", bus.lane_full); else n_pass++;
    n_total++; if (bus.lane_count[1] !== 3'd4) $display("FAIL ovf_count4 got=%0d exp=4", bus.lane_count[1]); else n_pass++;
    n_total++; if (bus.overflow_err !== 1'b0) $display("FAIL ovf_err_early got=%b exp=0", bus.overflow_err); else n_pass++;
    bus.pe_idle = 4'b0010;
    bus.task_packet[1] = 16'h0014;
    tick();
    n_total++; if (bus.lane_count[1] !== 3'd4) $display("FAIL ovf_pushpop_count got=%0d exp=4", bus.lane_count[1]); else n_pass++;
    n_total++; if (bus.overflow_err !== 1'b0) $display("FAIL ovf_pushpop_err got=%b exp=0", bus.overflow_err); else n_pass++;
    n_total++; if (bus.pe_packet[1] !== 16'h0010) $display("FAIL ovf_pushpop_packet got=%h exp=0010", bus.pe_packet[1]); else n_pass++;
    bus.pe_idle = '0;
    bus.task_packet[1] = 16'h0015;
    tick();
    bus.task_valid = '0;
    n_total++; if (bus.overflow_err !== 1'b1) $display("FAIL ovf_err_set got=%b exp=1", bus.overflow_err); else n_pass++;
    n_total++; if (bus.lane_count[1] !== 3'd4) $display("FAIL ovf_drop_count got=%0d exp=4", bus.lane_count[1]); else n_pass++;
    tick();
    n_total++; if (bus.overflow_err !== 1'b1) $display("FAIL ovf_err_sticky got=%b exp=1", bus.overflow_err); else n_pass++;
    bus.pe_done = 4'b0010;
    bus.pe_idle = 4'b0010;
    tick();
    bus.pe_done = '0;
    tick();
    n_total++; if (bus.pe_packet[1] !== 16'h0011) $display("FAIL ovf_order_packet got=%h exp=0011", bus.pe_packet[1]); else n_pass++;
    n_total++; if (bus.lane_count[1] !== 3'd3) $display("FAIL ovf_order_count got=%0d exp=3", bus.lane_count[1]); else n_pass++;
  endtask

  task automatic test_parallel();
    logic [15:0] exp_pkt [4];
    exp_pkt[0] = 16'h1111;
    exp_pkt[1] = 16'h2222;
    exp_pkt[2] = 16'h3333;
    exp_pkt[3] = 16'h4444;
    do_reset();
    bus.pe_idle = 4'hF;
    bus.task_valid = 4'hF;
    for (int i = 0; i < 4; i++) bus.task_packet[i] = exp_pkt[i];
    tick();
    bus.task_valid = '0;
    tick();
    n_total++; if (bus.pe_valid !== 4'hF) $display("FAIL par_valid got=%h exp=f", bus.pe_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (bus.pe_packet[i] !== exp_pkt[i]) $display("FAIL par_packet lane=%0d got=%h exp=%h", i, bus.pe_packet[i], exp_pkt[i]); else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [2:0] exp_cnt [4];
    exp_cnt[0] = 3'd2;
    exp_cnt[1] = 3'd3;
    exp_cnt[2] = 3'd0;
    exp_cnt[3] = 3'd1;
    do_reset();
    bus.task_packet = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    bus.task_valid = 4'b1011;
    tick();
    bus.task_valid = 4'b0011;
    tick();
    bus.task_valid = 4'b0010;
    tick();
    bus.task_valid = 4'b0001;
    bus.pe_idle = 4'b0001;
    tick();
    bus.task_valid = '0;
    bus.pe_idle = '0;
    n_total++; if (bus.pe_valid !== 4'b0001) $display("FAIL flush_pre_valid got=%h exp=1", bus.pe_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (bus.lane_count[i] !== exp_cnt[i]) $display("FAIL flush_pre_count lane=%0d got=%0d exp=%0d", i, bus.lane_count[i], exp_cnt[i]); else n_pass++;
    end
    bus.flush = 1'b1;
    bus.pe_idle = 4'hF;
    bus.task_valid = 4'b0010;
    tick();
    bus.flush = 1'b0;
    bus.task_valid = '0;
    n_total++; if (bus.lane_count !== '0) $display("FAIL flush_counts got=%h exp=0", bus.lane_count); else n_pass++;
    n_total++; if (bus.lane_full !== 4'h0) $display("FAIL flush_full got=%h exp=0", bus.lane_full); else n_pass++;
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL flush_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    n_total++; if (bus.overflow_err !== 1'b0) $display("FAIL flush_err got=%b exp=0", bus.overflow_err); else n_pass++;
    n_total++; if (bus.all_drained !== 1'b0) $display("FAIL flush_drained_busy got=%b exp=0", bus.all_drained); else n_pass++;
    tick();
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL flush_after_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    bus.pe_done = 4'b0001;
    tick();
    bus.pe_done = '0;
    n_total++; if (bus.all_drained !== 1'b1) $display("FAIL flush_drained_done got=%b exp=1", bus.all_drained); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.task_packet = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.task_valid = 4'hF;
    for (int k = 0; k < 5; k++) tick();
    bus.task_valid = '0;
    bus.pe_idle = 4'hF;
    tick();
    n_total++; if (bus.overflow_err !== 1'b1) $display("FAIL mrst_pre_err got=%b exp=1", bus.overflow_err); else n_pass++;
    n_total++; if (bus.lane_count[3] !== 3'd3) $display("FAIL mrst_pre_count got=%0d exp=3", bus.lane_count[3]); else n_pass++;
    reset = 1'b0;
    bus.pe_done = 4'hF;
    tick();
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL mrst_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    n_total++; if (bus.pe_packet !== '0) $display("FAIL mrst_packet got=%h exp=0", bus.pe_packet); else n_pass++;
    n_total++; if (bus.lane_full !== 4'h0) $display("FAIL mrst_full got=%h exp=0", bus.lane_full); else n_pass++;
    n_total++; if (bus.lane_count !== '0) $display("FAIL mrst_count got=%h exp=0", bus.lane_count); else n_pass++;
    n_total++; if (bus.all_drained !== 1'b1) $display("FAIL mrst_drained got=%b exp=1", bus.all_drained); else n_pass++;
    n_total++; if (bus.overflow_err !== 1'b0) $display("FAIL mrst_err got=%b exp=0", bus.overflow_err); else n_pass++;
    reset = 1'b1;
    bus.pe_done = '0;
    tick();
    n_total++; if (bus.pe_valid !== 4'h0) $display("FAIL mrst_after_valid got=%h exp=0", bus.pe_valid); else n_pass++;
    n_total++; if (bus.all_drained !== 1'b1) $display("FAIL mrst_after_drained got=%b exp=1", bus.all_drained); else n_pass++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_serialise();
    test_overflow();
    test_parallel();
    test_flush();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
